// File: rtl/trigger_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trigger_capture_ctrl
// Purpose  : Pre/post trigger capture sequencer. Forwards ADC samples to an
//            AXI-Stream output register while a capture is in progress,
//            counts pre- and post-trigger samples and marks the last beat.
// Option   : TRIGGER_CAPTURE_TIMEOUT_EN enables the WAIT_TRIG auto-trigger
//            timeout; when undefined, timeout_samples is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_capture_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_data_valid,
    input  logic                   trigger,
    input  logic [31:0]            trig_offset_in,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] pre_samples,
    input  logic [COUNT_WIDTH-1:0] post_samples,
    input  logic [COUNT_WIDTH-1:0] timeout_samples,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [31:0]            trig_offset,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   auto_trig
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  tdata_q;
    logic                   tvalid_q;
    logic                   tlast_q;
    logic                   overflow_q;
    logic [31:0]            trig_offset_q;
    logic [COUNT_WIDTH-1:0] pre_cnt_q;
    logic [COUNT_WIDTH-1:0] post_cnt_q;
    logic [COUNT_WIDTH-1:0] pre_cnt_d;
    logic [COUNT_WIDTH-1:0] post_cnt_d;
    logic [COUNT_WIDTH-1:0] post_target;
    logic                   active;
    logic                   room;
    logic                   fwd;
    logic                   drop;
    logic                   last_beat;

    // A sample moves only while capturing and the output register can take it;
    // abort suppresses forwarding in its own cycle so no partial tlast appears.
    assign active      = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    assign room        = !tvalid_q || m_axis_tready;
    assign fwd         = active && !abort && in_data_valid && room;
    assign drop        = active && !abort && in_data_valid && !room;
    assign pre_cnt_d   = (&pre_cnt_q)  ? pre_cnt_q  : pre_cnt_q  + CNT_ONE;
    assign post_cnt_d  = (&post_cnt_q) ? post_cnt_q : post_cnt_q + CNT_ONE;
    assign post_target = (post_samples == '0) ? CNT_ONE : post_samples;
    assign last_beat   = fwd && (post_cnt_d == post_target) &&
                         ((state_q == S_POST) || ((state_q == S_WAIT) && trigger));

`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
    logic                   auto_trig_q;
    logic [COUNT_WIDTH-1:0] to_cnt_q;
    logic [COUNT_WIDTH-1:0] to_cnt_d;
    logic                   to_hit;

    assign to_cnt_d  = (&to_cnt_q) ? to_cnt_q : to_cnt_q + CNT_ONE;
    assign to_hit    = fwd && (timeout_samples != '0) && (to_cnt_d == timeout_samples);
    assign auto_trig = auto_trig_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_samples;
    assign auto_trig      = 1'b0;
`endif

    // Capture sequencer together with the AXI-Stream output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            overflow_q    <= 1'b0;
            trig_offset_q <= '0;
            pre_cnt_q     <= '0;
            post_cnt_q    <= '0;
`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
            auto_trig_q   <= 1'b0;
            to_cnt_q      <= '0;
`endif
        end else begin
            if (fwd) begin
                tdata_q  <= in_data;
                tvalid_q <= 1'b1;
                tlast_q  <= last_beat;
            end else if (tvalid_q && m_axis_tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end

            if (active && abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (arm && !abort) begin
                            state_q     <= S_PRE;
                            pre_cnt_q   <= '0;
                            post_cnt_q  <= '0;
                            overflow_q  <= 1'b0;
`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
                            to_cnt_q    <= '0;
                            auto_trig_q <= 1'b0;
`endif
                        end
                    end
                    S_PRE: begin
                        if (fwd) begin
                            pre_cnt_q <= pre_cnt_d;
                        end
                        if ((pre_samples == '0) || (fwd && (pre_cnt_d == pre_samples))) begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (trigger) begin
                            trig_offset_q <= trig_offset_in;
                            if (fwd) begin
                                post_cnt_q <= post_cnt_d;
                            end
                            state_q <= last_beat ? S_DONE : S_POST;
                        end
`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
                        else begin
                            if (fwd) begin
                                to_cnt_q <= to_cnt_d;
                            end
                            if (to_hit) begin
                                state_q       <= S_POST;
                                auto_trig_q   <= 1'b1;
                                trig_offset_q <= trig_offset_in;
                            end
                        end
`endif
                    end
                    S_POST: begin
                        if (fwd) begin
                            post_cnt_q <= post_cnt_d;
                        end
                        if (last_beat) begin
                            state_q <= S_DONE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign trig_offset   = trig_offset_q;
    assign overflow      = overflow_q;
    assign busy          = active;
    assign done          = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_capture_ctrl
// Purpose  : Self-checking bench for trigger_capture_ctrl: directed capture
//            scenarios with literal expectations plus randomized traffic
//            compared every cycle against a behavioural capture model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_capture_ctrl;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_PRE  = 1;
    localparam int P_WT   = 2;
    localparam int P_POST = 3;
    localparam int P_DONE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_data_valid;
    logic          trigger;
    logic [31:0]   off_in;
    logic          arm;
    logic          abort;
    logic [CW-1:0] pre_s;
    logic [CW-1:0] post_s;
    logic [CW-1:0] to_s;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic [31:0]   toff;
    logic          busy;
    logic          done;
    logic          ovf;
    logic          autot;

    always #5 clk = ~clk;

    trigger_capture_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_data_valid   (in_data_valid),
        .trigger         (trigger),
        .trig_offset_in  (off_in),
        .arm             (arm),
        .abort           (abort),
        .pre_samples     (pre_s),
        .post_samples    (post_s),
        .timeout_samples (to_s),
        .m_axis_tdata    (tdata),
        .m_axis_tvalid   (tvalid),
        .m_axis_tready   (tready),
        .m_axis_tlast    (tlast),
        .trig_offset     (toff),
        .busy            (busy),
        .done            (done),
        .overflow        (ovf),
        .auto_trig       (autot)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // ---------------- behavioural capture model ----------------
    int          ph;
    int          n_pre, n_post, n_wait;
    logic [DW-1:0] e_data;
    bit          e_valid, e_last, e_ovf, e_auto;
    logic [31:0] e_off;
    bit          model_on = 0;
    bit          m_live, m_room, m_take, m_last;
    int          m_next, m_goal;

    always @(posedge clk) begin
        if (rst) begin
            ph = P_IDLE; n_pre = 0; n_post = 0; n_wait = 0;
            e_data = '0; e_valid = 0; e_last = 0; e_ovf = 0; e_auto = 0; e_off = '0;
            model_on = 1;
        end else begin
            m_live = (ph == P_PRE) || (ph == P_WT) || (ph == P_POST);
            m_room = !e_valid || tready;
            m_take = m_live && !abort && in_data_valid && m_room;
            m_goal = (post_s == 0) ? 1 : int'(post_s);
            m_last = 0;
            m_next = ph;
            if (m_live && !abort && in_data_valid && !m_room) e_ovf = 1;
            if (m_live && abort) begin
                m_next = P_IDLE;
            end else if (ph == P_IDLE || ph == P_DONE) begin
                if (arm && !abort) begin
                    m_next = P_PRE; n_pre = 0; n_post = 0; n_wait = 0; e_ovf = 0; e_auto = 0;
                end
            end else if (ph == P_PRE) begin
                if (m_take) n_pre = sat(n_pre + 1);
                if (pre_s == 0 || (m_take && n_pre == int'(pre_s))) m_next = P_WT;
            end else if (ph == P_WT && trigger) begin
                e_off = off_in;
                m_next = P_POST;
                if (m_take) begin
                    n_post = sat(n_post + 1);
                    if (n_post == m_goal) begin m_last = 1; m_next = P_DONE; end
                end
            end else if (ph == P_WT) begin
                if (m_take) n_wait = sat(n_wait + 1);
`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
                if (m_take && to_s != 0 && n_wait == int'(to_s)) begin
                    m_next = P_POST; e_auto = 1; e_off = off_in;
                end
`endif
            end else if (ph == P_POST) begin
                if (m_take) begin
                    n_post = sat(n_post + 1);
                    if (n_post == m_goal) begin m_last = 1; m_next = P_DONE; end
                end
            end
            if (m_take) begin
                e_data = in_data; e_valid = 1; e_last = m_last;
            end else if (e_valid && tready) begin
                e_valid = 0; e_last = 0;
            end
            ph = m_next;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_on) begin
            chk("tvalid", tvalid, e_valid);
            chk("tlast", tlast, e_last);
            chk("tdata", tdata, e_data);
            chk("trig_offset", toff, e_off);
            chk("busy", busy, (ph == P_PRE || ph == P_WT || ph == P_POST));
            chk("done", done, (ph == P_DONE));
            chk("overflow", ovf, e_ovf);
            chk("auto_trig", autot, e_auto);
        end
    end

    // Accepted-beat bookkeeping for the literal scenario checks
    int beats = 0, last_cnt = 0, last_idx = 0;
    always @(posedge clk) begin
        if (!rst && tvalid && tready) begin
            beats++;
            if (tlast) begin last_cnt++; last_idx = beats; end
        end
    end

    task automatic clr_beats();
        beats = 0; last_cnt = 0; last_idx = 0;
    endtask

    localparam logic [31:0] TRIG_VAL = 32'hCAFE_0040;

    task automatic cyc(input bit v, input bit trg = 0, input bit a = 0, input bit ab = 0);
        in_data_valid = v;
        trigger       = trg;
        arm           = a;
        abort         = ab;
        in_data       = DW'($urandom);
        off_in        = trg ? TRIG_VAL : $urandom;
        @(negedge clk);
        in_data_valid = 0; trigger = 0; arm = 0; abort = 0;
    endtask

    logic [DW-1:0] held;

    initial begin
        rst = 1; in_data_valid = 0; trigger = 0; arm = 0; abort = 0;
        in_data = '0; off_in = '0; tready = 1; pre_s = 0; post_s = 0; to_s = 0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_trig_offset", toff, 0);
        rst = 0;
        @(negedge clk);

        // Normal capture: pre=4, post=6, sparse samples, trigger after 10 waiting samples
        pre_s = 4; post_s = 6; to_s = 0; clr_beats();
        cyc(0, 0, 1);
        for (int i = 0; i < 84; i++) cyc(i % 6 == 0);
        cyc(0, 1);
        for (int i = 0; i < 42; i++) cyc(i % 6 == 0);
        repeat (3) cyc(0);
        chk("s1_beats", beats, 20);
        chk("s1_tlast_count", last_cnt, 1);
        chk("s1_tlast_index", last_idx, 20);
        chk("s1_done", done, 1);
        chk("s1_trig_offset", toff, TRIG_VAL);

        // Trigger during PRE is ignored
        pre_s = 8; post_s = 1; clr_beats();
        cyc(0, 0, 1);
        repeat (3) cyc(1);
        cyc(0, 1);
        repeat (5) cyc(1);
        repeat (4) cyc(0);
        chk("s2_busy", busy, 1);
        chk("s2_done", done, 0);
        chk("s2_beats", beats, 8);
        chk("s2_no_tlast", last_cnt, 0);
        cyc(1, 1);
        repeat (2) cyc(0);
        chk("s2_done_after", done, 1);
        chk("s2_tlast_index", last_idx, 9);

        // Backpressure: one beat held, the rest dropped and not counted
        pre_s = 2; post_s = 2; tready = 0; clr_beats();
        cyc(0, 0, 1);
        cyc(1);
        held = in_data;
        repeat (19) cyc(1);
        chk("s3_tdata_held", tdata, held);
        chk("s3_tvalid_held", tvalid, 1);
        chk("s3_overflow", ovf, 1);
        chk("s3_no_beats", beats, 0);
        tready = 1;
        cyc(0);
        chk("s3_beats_drain", beats, 1);
        cyc(1);
        cyc(1, 1);
        cyc(1);
        repeat (2) cyc(0);
        chk("s3_beats", beats, 4);
        chk("s3_tlast_index", last_idx, 4);
        chk("s3_done", done, 1);

        // post_samples == 0 behaves as one
        pre_s = 0; post_s = 0; clr_beats();
        cyc(0, 0, 1);
        cyc(0);
        cyc(1, 1);
        repeat (2) cyc(0);
        chk("s4_beats", beats, 1);
        chk("s4_tlast_count", last_cnt, 1);
        chk("s4_done", done, 1);

        // Abort in POST, then a fresh capture
        pre_s = 1; post_s = 8; clr_beats();
        cyc(0, 0, 1);
        cyc(1);
        cyc(1, 1);
        cyc(1);
        cyc(1);
        cyc(0, 0, 0, 1);
        chk("s5_busy", busy, 0);
        chk("s5_done", done, 0);
        repeat (2) cyc(0);
        chk("s5_no_tlast", last_cnt, 0);
        chk("s5_beats", beats, 4);
        post_s = 1;
        cyc(0, 0, 1);
        cyc(1);
        cyc(1, 1);
        repeat (2) cyc(0);
        chk("s5_rearm_done", done, 1);
        chk("s5_rearm_tlast", last_cnt, 1);
        chk("s5_rearm_beats", beats, 6);

        // Timeout behaviour
        pre_s = 1; post_s = 2; to_s = 5; clr_beats();
        cyc(0, 0, 1);
        cyc(1);
        repeat (5) cyc(1);
`ifdef TRIGGER_CAPTURE_TIMEOUT_EN
        chk("s6_auto_trig", autot, 1);
        chk("s6_busy", busy, 1);
        cyc(1);
        cyc(1);
        repeat (2) cyc(0);
        chk("s6_done", done, 1);
        chk("s6_beats", beats, 8);
`else
        chk("s6_auto_trig", autot, 0);
        repeat (10) cyc(1);
        chk("s6_busy", busy, 1);
        chk("s6_done", done, 0);
        cyc(0, 0, 0, 1);
`endif
        to_s = 0;

        // Randomized traffic checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pre_s  = CW'($urandom_range(0, 5));
                post_s = CW'($urandom_range(0, 5));
                to_s   = CW'($urandom_range(0, 6));
            end
            tready = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 399) == 0);
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
            rst = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
